// File: rtl/vslc_pkg.sv
// Shared VSLC definitions: counter FSM states and the default datapath width
// used by the timer, event counter and logic core.
package vslc_pkg;

  localparam int VSLC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vslc_state_e;

endpackage

// File: rtl/vslc_edge_detect.sv
// Rising-edge detector for a same-clock logic signal. The history register
// is loaded with the live input during reset so a level held high across
// reset release is never seen as an edge.
module vslc_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic prev;

  // History tracks the input every cycle, in reset or not.
  always_ff @(posedge clk) begin
    if (!rst_n) prev <= sig;
    else        prev <= sig;
  end

  assign rise = rst_n & sig & ~prev;

endmodule

// File: rtl/vslc_event_counter.sv
// PLC-style up/down event counter with preset, one-shot or auto-reload
// completion, and sticky overflow/underflow flags.
module vslc_event_counter
  import vslc_pkg::*;
#(
  parameter int WIDTH = VSLC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cu_in,
  input  logic             cd_in,
  input  logic [WIDTH-1:0] preset,
  input  logic             mode_reload,
  input  logic             load,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count_o,
  output logic             done,
  output logic             done_pulse,
  output logic             ovf,
  output logic             unf
);

  logic            up_e;
  logic            dn_e;
  vslc_state_e     state_q;
  vslc_state_e     state_d;
  vslc_state_e     eff_state;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   count_inc;
  logic            done_d;
  logic            pulse_d;
  logic            ovf_set;
  logic            unf_set;

  vslc_edge_detect u_cu_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (cu_in),
    .rise  (up_e)
  );

  vslc_edge_detect u_cd_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (cd_in),
    .rise  (dn_e)
  );

  // One extra bit so a count at all-ones still compares correctly against preset.
  assign count_inc = {1'b0, count_o} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    count_d   = count_o;
    done_d    = done;
    pulse_d   = 1'b0;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    eff_state = (state_q == IDLE) ? RUN : state_q;

    if (load) begin
      count_d = '0;
      done_d  = 1'b0;
      state_d = enable ? RUN : IDLE;
    end else if (!enable) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      state_d = eff_state;
      // Leaving IDLE takes effect immediately, so this cycle's edges count as RUN.
      case (eff_state)
        RUN: begin
          if (up_e && !dn_e) begin
            if ((preset != '0) && (count_inc >= {1'b0, preset})) begin
              pulse_d = 1'b1;
              if (mode_reload) begin
                count_d = '0;
              end else begin
                count_d = preset;
                done_d  = 1'b1;
                state_d = DONE;
              end
            end else begin
              count_d = count_inc[WIDTH-1:0];
              ovf_set = count_inc[WIDTH];
            end
          end else if (dn_e && !up_e) begin
            if (count_o != '0) count_d = count_o - {{(WIDTH-1){1'b0}}, 1'b1};
            else               unf_set = 1'b1;
          end
        end
        DONE: begin
          if (dn_e && !up_e) begin
            count_d = count_o - {{(WIDTH-1){1'b0}}, 1'b1};
            done_d  = 1'b0;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_o    <= '0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_o    <= count_d;
      done       <= done_d;
      done_pulse <= pulse_d;
      ovf        <= ovf_set | (ovf & ~clear_flags);
      unf        <= unf_set | (unf & ~clear_flags);
    end
  end

endmodule
